// File: rtl/not_arb_pkg.sv
// Shared definitions for the shared inverter arbiter: state encoding and default widths.
package not_arb_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_HOLD = 1'b1;

   localparam int unsigned DEF_N     = 4;
   localparam int unsigned DEF_WIDTH = 8;
   localparam int unsigned DEF_CNT_W = 16;

   // IDLE: output register empty; HOLD: output register full, awaiting res_ready
   typedef enum logic {
      IDLE = ST_IDLE,
      HOLD = ST_HOLD
   } state_e;

endpackage : not_arb_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr.
// Ports:
//   req       - per-requester request bits
//   ptr       - highest-priority index for this cycle
//   en        - grant enable; no grant is issued when low
//   grant     - one-hot grant (zero when nothing is granted)
//   grant_idx - index of the granted requester (0 when none)
//   any       - a grant is issued this cycle
module rr_arbiter #(
   parameter  int unsigned N    = 4,
   localparam int unsigned ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   input  logic            en,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_idx,
   output logic            any
);

   logic [ID_W-1:0] cand;

   // Rotating search starting at ptr; the first hit wins
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      cand      = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = ID_W'((32'(ptr) + k) % N);
         if (en && !any && req[cand]) begin
            any         = 1'b1;
            grant_idx   = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule : rr_arbiter

// File: rtl/shared_not_arbiter.sv
// One registered WIDTH-bit inverter shared round-robin among N requesters,
// with a wrapping count of completed result handshakes.
// Ports:
//   clk, rst   - clock; synchronous active-high reset
//   req_valid  - per-requester valid
//   req_data   - packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready  - one-hot accept (combinational from req_valid/state/ptr/res_ready)
//   res_valid  - result valid (registered)
//   res_data   - inverted operand (registered)
//   res_id     - index of the requester that produced res_data (registered)
//   res_ready  - sink accepts the result
//   txn_count  - completed result handshakes, wraps
module shared_not_arbiter
   import not_arb_pkg::*;
#(
   parameter  int unsigned N     = DEF_N,
   parameter  int unsigned WIDTH = DEF_WIDTH,
   parameter  int unsigned CNT_W = DEF_CNT_W,
   localparam int unsigned ID_W  = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_valid,
   input  logic [N*WIDTH-1:0]   req_data,
   output logic [N-1:0]         req_ready,
   output logic                 res_valid,
   output logic [WIDTH-1:0]     res_data,
   output logic [ID_W-1:0]      res_id,
   input  logic                 res_ready,
   output logic [CNT_W-1:0]     txn_count
);

   state_e           state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [WIDTH-1:0] res_data_q, res_data_d;
   logic [ID_W-1:0]  res_id_q, res_id_d;
   logic [CNT_W-1:0] txn_q, txn_d;

   logic [WIDTH-1:0] opnd_c [N];
   logic [N-1:0]     grant_c;
   logic [ID_W-1:0]  grant_idx_c;
   logic             accept_c;
   logic             can_accept_c;
   logic             res_fire_c;

   // Unpacked view of the operand bus
   for (genvar i = 0; i < N; i++) begin : g_opnd
      assign opnd_c[i] = req_data[i*WIDTH +: WIDTH];
   end

   // A slot is free when empty, or when the current result leaves this cycle
   assign can_accept_c = ~rst & ((state_q == IDLE) | res_ready);
   assign res_fire_c   = (state_q == HOLD) & res_ready;

   rr_arbiter #(.N(N)) u_arb (
      .req       (req_valid),
      .ptr       (ptr_q),
      .en        (can_accept_c),
      .grant     (grant_c),
      .grant_idx (grant_idx_c),
      .any       (accept_c)
   );

   // Next-state: a same-cycle accept overrides the drain to IDLE
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      res_data_d = res_data_q;
      res_id_d   = res_id_q;
      txn_d      = txn_q;
      if (res_fire_c) begin
         txn_d   = txn_q + CNT_W'(1);
         state_d = IDLE;
      end
      if (accept_c) begin
         res_data_d = ~opnd_c[grant_idx_c];
         res_id_d   = grant_idx_c;
         state_d    = HOLD;
         ptr_d      = ID_W'((32'(grant_idx_c) + 32'd1) % N);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         res_data_q <= '0;
         res_id_q   <= '0;
         txn_q      <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         res_data_q <= res_data_d;
         res_id_q   <= res_id_d;
         txn_q      <= txn_d;
      end
   end

   assign req_ready = grant_c;
   assign res_valid = (state_q == HOLD);
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;
   assign txn_count = txn_q;

endmodule : shared_not_arbiter

// File: tb/tb_shared_not_arbiter.sv
// Directed + randomized bench for shared_not_arbiter against a behavioural model.
module tb_shared_not_arbiter;

   localparam int unsigned N     = 4;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned ID_W  = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N-1:0]         req_valid;
   logic [N*WIDTH-1:0]   req_data;
   logic [N-1:0]         req_ready;
   logic                 res_valid;
   logic [WIDTH-1:0]     res_data;
   logic [ID_W-1:0]      res_id;
   logic                 res_ready;
   logic [CNT_W-1:0]     txn_count;

   always #5 clk = ~clk;

   shared_not_arbiter #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .res_valid (res_valid),
      .res_data  (res_data),
      .res_id    (res_id),
      .res_ready (res_ready),
      .txn_count (txn_count)
   );

   int tests = 0;
   int fails = 0;

   // Behavioural model: one result slot, a priority pointer, a handshake count
   bit         m_full;
   logic [7:0] m_data;
   int         m_id, m_ptr, m_cnt;
   int         m_g;
   int         last_g;
   logic [N-1:0] obs_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [7:0] d);
      req_data[i*WIDTH +: WIDTH] = d;
   endtask

   function automatic int pick();
      if (rst || (m_full && !res_ready)) return -1;
      for (int k = 0; k < int'(N); k++) begin
         int idx;
         idx = (m_ptr + k) % int'(N);
         if (req_valid[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_full = 1'b0; m_data = 8'h00; m_id = 0; m_ptr = 0; m_cnt = 0;
   endtask

   // One clock: check everything mid-cycle, then advance the model at the edge
   task automatic cyc();
      logic [N-1:0] exp_ready;
      @(negedge clk);
      m_g       = pick();
      exp_ready = (m_g >= 0) ? N'(1 << m_g) : '0;
      obs_ready = req_ready;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("res_valid", 32'(res_valid), 32'(m_full));
      chk("res_data",  32'(res_data),  32'(m_data));
      chk("res_id",    32'(res_id),    32'(m_id));
      chk("txn_count", 32'(txn_count), 32'(m_cnt));
      @(posedge clk);
      last_g = -1;
      if (rst) begin
         model_reset();
      end else begin
         if (m_full && res_ready) begin
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            m_full = 1'b0;
         end
         if (m_g >= 0) begin
            m_data = ~req_data[m_g*WIDTH +: WIDTH];
            m_id   = m_g;
            m_full = 1'b1;
            m_ptr  = (m_g + 1) % int'(N);
            last_g = m_g;
         end
      end
      #1;
   endtask

   initial begin
      // Reset with all requesters asserted
      rst = 1'b1; req_valid = 4'b1111; res_ready = 1'b0;
      for (int i = 0; i < int'(N); i++) set_req(i, 8'($urandom));
      @(posedge clk); #1;
      model_reset();
      last_g = -1;
      cyc();
      chk("reset_res_data", 32'(res_data), 32'h00);
      chk("reset_txn", 32'(txn_count), 32'h0);

      // Released with no requests
      rst = 1'b0; req_valid = 4'b0000;
      cyc();
      chk("idle_no_ready", 32'(obs_ready), 32'h0);

      // Single request from requester 2
      req_valid = 4'b0100; set_req(2, 8'hA5); res_ready = 1'b1;
      cyc();
      chk("single_ready", 32'(obs_ready), 32'b0100);
      req_valid = 4'b0000;
      chk("single_valid", 32'(res_valid), 32'h1);
      chk("single_data", 32'(res_data), 32'h5A);
      chk("single_id", 32'(res_id), 32'h2);
      cyc();
      chk("single_txn", 32'(txn_count), 32'h1);

      // All requesting continuously: pointer now at 3
      req_valid = 4'b1111;
      for (int k = 0; k < 8; k++) begin
         cyc();
         chk("rr_order", 32'(obs_ready), 32'(1 << ((3 + k) % 4)));
         if (last_g >= 0) set_req(last_g, 8'($urandom));
      end

      // Backpressure with a held 8'hF0 result
      req_valid = 4'b0001; set_req(0, 8'h0F);
      cyc();
      req_valid = 4'b1110; res_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk("bp_hold_data", 32'(res_data), 32'hF0);
         chk("bp_no_ready", 32'(obs_ready), 32'h0);
      end
      res_ready = 1'b1;
      cyc();
      chk("bp_release_grant", 32'(obs_ready), 32'b0010);
      chk("bp_release_id", 32'(res_id), 32'h1);

      // Reset while holding an unaccepted result
      req_valid = 4'b1100; res_ready = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0; req_valid = 4'b0000;
      chk("mid_rst_valid", 32'(res_valid), 32'h0);
      chk("mid_rst_txn", 32'(txn_count), 32'h0);
      res_ready = 1'b1;
      cyc();
      chk("mid_rst_discard", 32'(res_valid), 32'h0);

      // Counter wrap: 17 back-to-back cycles give 16 handshakes
      req_valid = 4'b1111;
      for (int k = 0; k < 17; k++) begin
         cyc();
         if (k == 0) chk("post_rst_ptr0", 32'(obs_ready), 32'b0001);
         if (last_g >= 0) set_req(last_g, 8'($urandom));
      end
      chk("txn_wrap", 32'(txn_count), 32'h0);
      chk("wrap_still_valid", 32'(res_valid), 32'h1);

      // Randomized traffic: requesters hold until accepted
      for (int c = 0; c < 400; c++) begin
         if (last_g >= 0 && $urandom_range(0, 1) == 0) req_valid[last_g] = 1'b0;
         else if (last_g >= 0) set_req(last_g, 8'($urandom));
         for (int i = 0; i < int'(N); i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
               req_valid[i] = 1'b1;
               set_req(i, 8'($urandom));
            end
         end
         res_ready = ($urandom_range(0, 3) != 0);
         rst = ($urandom_range(0, 99) == 0);
         cyc();
         rst = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_shared_not_arbiter
